// File: rtl/multi_channel_score_display.sv
// Multi-channel 7-segment score readout with one shared sequential double-dabble engine.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
`timescale 1ns/1ps

module multi_channel_score_display #(
   parameter int  INPUT_LENGTH = 8,
   parameter int  N_DIGITS     = 2,
   parameter int  N_CHANNELS   = 2,
   localparam int CW           = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
   input  logic                               clock,
   input  logic                               reset_n,
   input  logic [N_CHANNELS-1:0]              update,
   input  logic [N_CHANNELS*INPUT_LENGTH-1:0] binary,
   output logic [N_CHANNELS*N_DIGITS*4-1:0]   bcd,
   output logic [N_CHANNELS*N_DIGITS*7-1:0]   segments,
   output logic [N_CHANNELS-1:0]              overflow,
   output logic                               busy,
   output logic                               done,
   output logic [CW-1:0]                      done_channel
);

   localparam int     BW    = N_DIGITS * 4;
   localparam int     SW    = N_DIGITS * 7;
   localparam int     CNTW  = $clog2(INPUT_LENGTH + 1);
   localparam longint LIMIT = longint'(10) ** N_DIGITS;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE} state_t;

   state_t                   state_q, state_d;
   logic [N_CHANNELS-1:0]    pending_q, pending_d;
   logic [CW-1:0]            sel_q, sel_d;
   logic [INPUT_LENGTH-1:0]  shift_q, shift_d;
   logic [BW-1:0]            acc_q, acc_d;
   logic [CNTW-1:0]          cnt_q, cnt_d;
   logic                     ovf_q, ovf_d;
   logic [N_CHANNELS*BW-1:0] bcd_q, bcd_d;
   logic [N_CHANNELS*SW-1:0] seg_q, seg_d;
   logic [N_CHANNELS-1:0]    overflow_q, overflow_d;
   logic                     done_q, done_d;
   logic [CW-1:0]            done_channel_q, done_channel_d;

   logic [BW-1:0]            acc_adj;
   logic [BW-1:0]            acc_shift;
   logic [INPUT_LENGTH-1:0]  bin_shift;
   logic [INPUT_LENGTH-1:0]  bin_sel;
   logic [SW-1:0]            digit_seg;
   logic [N_DIGITS-1:0]      blank;
   logic [CW-1:0]            pick;
   logic [N_CHANNELS-1:0]    clear;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0:    seg_of = 7'b1000000;
         4'd1:    seg_of = 7'b1111001;
         4'd2:    seg_of = 7'b0100100;
         4'd3:    seg_of = 7'b0110000;
         4'd4:    seg_of = 7'b0011001;
         4'd5:    seg_of = 7'b0010010;
         4'd6:    seg_of = 7'b0000010;
         4'd7:    seg_of = 7'b1111000;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0010000;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

   // Add-3 correction is applied before each shift; carries out of the top digit are dropped.
   genvar gi;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ? acc_q[gi*4 +: 4] + 4'd3
                                                                 : acc_q[gi*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
         assign blank[gi] = (gi != 0) && (acc_q[BW-1:gi*4] == '0);
`else
         assign blank[gi] = 1'b0;
`endif
         assign digit_seg[gi*7 +: 7] = ovf_q     ? SEG_DASH  :
                                       blank[gi] ? SEG_BLANK : seg_of(acc_q[gi*4 +: 4]);
      end
   endgenerate

   assign acc_shift = {acc_adj[BW-2:0], shift_q[INPUT_LENGTH-1]};
   assign bin_shift = {shift_q[INPUT_LENGTH-2:0], 1'b0};
   assign bin_sel   = binary[sel_q*INPUT_LENGTH +: INPUT_LENGTH];

   always_comb begin
      pick = '0;
      for (int i = N_CHANNELS - 1; i >= 0; i--) begin
         if (pending_q[i]) pick = CW'(i);
      end
   end

   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      shift_d        = shift_q;
      acc_d          = acc_q;
      cnt_d          = cnt_q;
      ovf_d          = ovf_q;
      bcd_d          = bcd_q;
      seg_d          = seg_q;
      overflow_d     = overflow_q;
      done_d         = 1'b0;
      done_channel_d = done_channel_q;
      clear          = '0;
      case (state_q)
         S_IDLE: begin
            if (|pending_q) begin
               sel_d        = pick;
               clear[pick]  = 1'b1;
               state_d      = S_LOAD;
            end
         end
         S_LOAD: begin
            shift_d = bin_sel;
            acc_d   = '0;
            cnt_d   = CNTW'(INPUT_LENGTH);
            ovf_d   = (64'(bin_sel) >= LIMIT);
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            acc_d   = acc_shift;
            shift_d = bin_shift;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CNTW'(1)) state_d = S_STORE;
         end
         S_STORE: begin
            bcd_d[sel_q*BW +: BW] = acc_q;
            seg_d[sel_q*SW +: SW] = digit_seg;
            overflow_d[sel_q]     = ovf_q;
            done_d                = 1'b1;
            done_channel_d        = sel_q;
            state_d               = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A new request on the channel just cleared wins, so it is converted again later.
      pending_d = (pending_q & ~clear) | update;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         pending_q      <= '0;
         sel_q          <= '0;
         shift_q        <= '0;
         acc_q          <= '0;
         cnt_q          <= '0;
         ovf_q          <= 1'b0;
         bcd_q          <= '0;
         seg_q          <= '1;
         overflow_q     <= '0;
         done_q         <= 1'b0;
         done_channel_q <= '0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         sel_q          <= sel_d;
         shift_q        <= shift_d;
         acc_q          <= acc_d;
         cnt_q          <= cnt_d;
         ovf_q          <= ovf_d;
         bcd_q          <= bcd_d;
         seg_q          <= seg_d;
         overflow_q     <= overflow_d;
         done_q         <= done_d;
         done_channel_q <= done_channel_d;
      end
   end

   assign bcd          = bcd_q;
   assign segments     = seg_q;
   assign overflow     = overflow_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign done_channel = done_channel_q;

endmodule

// File: tb/tb_multi_channel_score_display.sv
// Directed bench for multi_channel_score_display (2 channels, 2 digits, 8-bit scores).
`timescale 1ns/1ps

module tb_multi_channel_score_display;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] DASH = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = S0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  update = 2'b00;
   logic [15:0] binary = 16'd0;
   logic [15:0] bcd;
   logic [27:0] segments;
   logic [1:0]  overflow;
   logic        busy;
   logic        done;
   logic [0:0]  done_channel;

   int checks = 0;
   int failures = 0;
   int cyc;
   int busy_low;
   int cnt;

   multi_channel_score_display dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .update       (update),
      .binary       (binary),
      .bcd          (bcd),
      .segments     (segments),
      .overflow     (overflow),
      .busy         (busy),
      .done         (done),
      .done_channel (done_channel)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [1:0] m);
      update = m;
      @(posedge clock); #1;
      update = 2'b00;
   endtask

   task automatic wait_done(output int n, output int bl);
      n  = 0;
      bl = 0;
      do begin
         @(posedge clock); #1;
         n++;
         if (!done && !busy) bl++;
      end while (!done && n < 50);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bcd"}, bcd, 16'h0000);
      check({tag, "_seg"}, segments, 28'hFFFFFFF);
      check({tag, "_ovf"}, overflow, 2'b00);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_dch"}, done_channel, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(posedge clock); #1;

      // ch0 = 42
      binary[7:0] = 8'd42;
      pulse(2'b01);
      wait_done(cyc, busy_low);
      check("lat42", cyc, 11);
      check("dch42", done_channel, 1'b0);
      check("bcd42", bcd[7:0], 8'h42);
      check("seg42", segments[13:0], {S4, S2});
      check("ch1_bcd_held", bcd[15:8], 8'h00);
      check("ch1_seg_held", segments[27:14], 14'h3FFF);
      check("busy42", busy_low, 0);
      check("ovf42", overflow, 2'b00);
      @(posedge clock); #1;
      check("done_pulse", done, 1'b0);

      // simultaneous ch0 = 5, ch1 = 99
      binary = {8'd99, 8'd5};
      pulse(2'b11);
      wait_done(cyc, busy_low);
      check("lat_sim0", cyc, 11);
      check("dch_sim0", done_channel, 1'b0);
      check("bcd5", bcd[7:0], 8'h05);
      check("seg5", segments[13:0], {LZ, S5});
      check("busy_sim0", busy_low, 0);
      wait_done(cyc, busy_low);
      check("lat_sim1", cyc, 11);
      check("dch_sim1", done_channel, 1'b1);
      check("bcd99", bcd[15:8], 8'h99);
      check("seg99", segments[27:14], {S9, S9});
      check("busy_sim1", busy_low, 0);
      check("ovf99", overflow, 2'b00);

      // ch1 = 150 overflows
      binary[15:8] = 8'd150;
      pulse(2'b10);
      wait_done(cyc, busy_low);
      check("dch150", done_channel, 1'b1);
      check("ovf150", overflow, 2'b10);
      check("seg150", segments[27:14], {DASH, DASH});
      check("bcd150", bcd[15:8], 8'h50);
      check("ch0_held", bcd[7:0], 8'h05);

      // boundary 100 overflows, 99 does not
      binary[15:8] = 8'd100;
      pulse(2'b10);
      wait_done(cyc, busy_low);
      check("ovf100", overflow, 2'b10);
      check("bcd100", bcd[15:8], 8'h00);
      binary[15:8] = 8'd99;
      pulse(2'b10);
      wait_done(cyc, busy_low);
      check("ovf99b", overflow, 2'b00);
      check("seg99b", segments[27:14], {S9, S9});

      // ch0 = 0
      binary[7:0] = 8'd0;
      pulse(2'b01);
      wait_done(cyc, busy_low);
      check("bcd0", bcd[7:0], 8'h00);
      check("seg0", segments[13:0], {LZ, S0});

      // re-request during SHIFT, value changes 3 -> 7
      binary[7:0] = 8'd3;
      pulse(2'b01);
      repeat (3) begin
         @(posedge clock); #1;
      end
      check("rereq_busy", busy, 1'b1);
      binary[7:0] = 8'd7;
      pulse(2'b01);
      wait_done(cyc, busy_low);
      check("rereq_lat1", cyc, 7);
      check("bcd3", bcd[7:0], 8'h03);
      check("seg3", segments[13:0], {LZ, S3});
      wait_done(cyc, busy_low);
      check("rereq_lat2", cyc, 11);
      check("bcd7", bcd[7:0], 8'h07);
      check("seg7", segments[13:0], {LZ, S7});
      cnt = 0;
      repeat (15) begin
         @(posedge clock); #1;
         if (done) cnt++;
      end
      check("rereq_extra_done", cnt, 0);

      // reset mid-SHIFT
      binary[7:0] = 8'd42;
      pulse(2'b01);
      repeat (4) begin
         @(posedge clock); #1;
      end
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge clock); #1;
      reset_n = 1'b1;
      cnt = 0;
      busy_low = 0;
      repeat (20) begin
         @(posedge clock); #1;
         if (done) cnt++;
         if (busy) busy_low++;
      end
      check("postreset_done", cnt, 0);
      check("postreset_busy", busy_low, 0);
      check("postreset_bcd", bcd, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
